// File: rtl/niosvprocessor_sram_arb_pkg.sv
// Shared types and default sizes for the Nios V on-chip SRAM arbiter.
package niosvprocessor_sram_arb_pkg;

  localparam int          DEF_ADDR_W = 17;
  localparam int          DEF_DATA_W = 32;
  localparam int unsigned DEF_WORDS  = 125000;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } arb_state_t;

  // One in-flight read: valid flag, owning port, out-of-range flag.
  typedef struct packed {
    logic     vld;
    port_id_t id;
    logic     oor;
  } rd_pipe_t;

endpackage

// File: rtl/niosvprocessor_sram_rr_arb.sv
// Two-way grant logic with a last-grant register; round-robin or fixed A-priority.
module niosvprocessor_sram_rr_arb
  import niosvprocessor_sram_arb_pkg::*;
#(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     req_a,
  input  logic     req_b,
  input  logic     grant_en,
  output logic     gnt_a,
  output logic     gnt_b,
  output port_id_t gnt_id
);

  port_id_t last_grant;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (grant_en) begin
      if (req_a && req_b) begin
        // Under contention A wins when it did not win last time, or always with fixed priority.
        if (FIXED_PRIORITY || last_grant == PORT_B) gnt_a = 1'b1;
        else                                        gnt_b = 1'b1;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
    gnt_id = gnt_b ? PORT_B : PORT_A;
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
    if (reset)      last_grant <= PORT_B;
    else if (gnt_a) last_grant <= PORT_A;
    else if (gnt_b) last_grant <= PORT_B;
  end

endmodule

// File: rtl/niosvprocessor_sram_arbiter.sv
// Two-master arbiter for the single-port SRAM with read-return steering and reset_req sequencing.
module niosvprocessor_sram_arbiter
  import niosvprocessor_sram_arb_pkg::*;
#(
  parameter int          ADDR_W         = DEF_ADDR_W,
  parameter int          DATA_W         = DEF_DATA_W,
  parameter int unsigned WORDS          = DEF_WORDS,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W/8-1:0] a_byteenable,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [DATA_W-1:0]   a_writedata,
  output logic                a_waitrequest,
  output logic                a_readdatavalid,
  output logic [DATA_W-1:0]   a_readdata,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic [DATA_W/8-1:0] b_byteenable,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [DATA_W-1:0]   b_writedata,
  output logic                b_waitrequest,
  output logic                b_readdatavalid,
  output logic [DATA_W-1:0]   b_readdata,
  output logic [ADDR_W-1:0]   sram_address,
  output logic [DATA_W/8-1:0] sram_byteenable,
  output logic                sram_chipselect,
  output logic                sram_write,
  output logic [DATA_W-1:0]   sram_writedata,
  output logic                sram_clken,
  output logic                sram_reset_req,
  input  logic [DATA_W-1:0]   sram_readdata,
  input  logic                reset_req_in,
  output logic                reset_ack
);

  arb_state_t state, state_next;
  rd_pipe_t   rd_q, rd_d;
  logic       grant_en, gnt_a, gnt_b, any_gnt;
  port_id_t   gnt_id;
  logic       win_read, win_write, win_oor;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (reset_req_in) state_next = DRAIN;
      DRAIN:   if (!reset_req_in) state_next = RUN;
               else if (!rd_q.vld) state_next = HALT;
      HALT:    if (!reset_req_in) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Decoding the next state lets the cycle that raises reset_req_in already block grants.
  assign grant_en = !reset && (state == RUN) && (state_next == RUN);

  niosvprocessor_sram_rr_arb #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_rr_arb (
    .clk     (clk),
    .reset   (reset),
    .req_a   (a_read | a_write),
    .req_b   (b_read | b_write),
    .grant_en(grant_en),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .gnt_id  (gnt_id)
  );

  assign any_gnt         = gnt_a | gnt_b;
  assign sram_address    = gnt_b ? b_address    : a_address;
  assign sram_byteenable = gnt_b ? b_byteenable : a_byteenable;
  assign sram_writedata  = gnt_b ? b_writedata  : a_writedata;
  assign win_read        = gnt_b ? b_read       : a_read;
  assign win_write       = gnt_b ? b_write      : a_write;
  assign win_oor         = 32'(sram_address) >= WORDS;

  // Out-of-range accesses are still accepted, but never reach the memory.
  assign sram_chipselect = any_gnt && !win_oor;
  assign sram_write      = sram_chipselect && win_write;
  assign a_waitrequest   = !gnt_a;
  assign b_waitrequest   = !gnt_b;

  assign rd_d.vld = any_gnt && win_read;
  assign rd_d.id  = gnt_id;
  assign rd_d.oor = win_oor;

  always_ff @(posedge clk) begin
    if (reset) rd_q <= '0;
    else       rd_q <= rd_d;
  end

  assign rd_data         = rd_q.oor ? '0 : sram_readdata;
  assign a_readdatavalid = !reset && rd_q.vld && (rd_q.id == PORT_A);
  assign b_readdatavalid = !reset && rd_q.vld && (rd_q.id == PORT_B);
  assign a_readdata      = a_readdatavalid ? rd_data : '0;
  assign b_readdata      = b_readdatavalid ? rd_data : '0;

  assign sram_clken     = reset || (state != HALT);
  assign sram_reset_req = !reset && (state == HALT);
  assign reset_ack      = !reset && (state == HALT);

endmodule

// File: tb/tb_niosvprocessor_sram_arbiter.sv
// Scoreboard bench: SRAM model, reference memory and queued read expectations per port.
module tb_niosvprocessor_sram_arbiter;

  localparam int          ADDR_W = 17;
  localparam int          DATA_W = 32;
  localparam int unsigned WORDS  = 125000;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] a_address, b_address;
  logic [3:0]        a_byteenable, b_byteenable;
  logic              a_read, a_write, b_read, b_write;
  logic [31:0]       a_writedata, b_writedata;
  logic              a_waitrequest, a_readdatavalid, b_waitrequest, b_readdatavalid;
  logic [31:0]       a_readdata, b_readdata;
  logic [ADDR_W-1:0] sram_address;
  logic [3:0]        sram_byteenable;
  logic              sram_chipselect, sram_write, sram_clken, sram_reset_req;
  logic [31:0]       sram_writedata, sram_readdata;
  logic              reset_req_in, reset_ack;

  niosvprocessor_sram_arbiter dut (
    .clk(clk), .reset(reset),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read), .a_write(a_write),
    .a_writedata(a_writedata), .a_waitrequest(a_waitrequest),
    .a_readdatavalid(a_readdatavalid), .a_readdata(a_readdata),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read), .b_write(b_write),
    .b_writedata(b_writedata), .b_waitrequest(b_waitrequest),
    .b_readdatavalid(b_readdatavalid), .b_readdata(b_readdata),
    .sram_address(sram_address), .sram_byteenable(sram_byteenable),
    .sram_chipselect(sram_chipselect), .sram_write(sram_write),
    .sram_writedata(sram_writedata), .sram_clken(sram_clken),
    .sram_reset_req(sram_reset_req), .sram_readdata(sram_readdata),
    .reset_req_in(reset_req_in), .reset_ack(reset_ack)
  );

  always #5 clk = ~clk;

  // SRAM model: registered address, output valid one cycle after the edge.
  logic [31:0] mem [0:WORDS-1];
  logic [31:0] mem_rd_q;
  always @(posedge clk) begin
    if (sram_clken && sram_chipselect) begin
      if (sram_write) begin
        for (int l = 0; l < 4; l++)
          if (sram_byteenable[l]) mem[sram_address][8*l +: 8] <= sram_writedata[8*l +: 8];
      end else begin
        mem_rd_q <= mem[sram_address];
      end
    end
  end
  assign sram_readdata = mem_rd_q;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [int];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_read(input int addr);
    if (addr >= int'(WORDS) || !ref_mem.exists(addr)) return 32'h0;
    return ref_mem[addr];
  endfunction

  task automatic ref_write(input int addr, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    if (addr >= int'(WORDS)) return;
    w = ref_read(addr);
    for (int l = 0; l < 4; l++) if (be[l]) w[8*l +: 8] = d[8*l +: 8];
    ref_mem[addr] = w;
  endtask

  // One bus cycle: inputs already driven; sample at negedge, then advance past posedge.
  task automatic step(input logic exp_ga, input logic exp_gb);
    logic        ev_a, ev_b;
    logic [31:0] ed_a, ed_b;
    exp_t        e;
    @(negedge clk);
    ev_a = 1'b0; ev_b = 1'b0; ed_a = '0; ed_b = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.port == 1'b0) begin ev_a = 1'b1; ed_a = e.data; end
      else                begin ev_b = 1'b1; ed_b = e.data; end
    end
    check("a_waitrequest", 32'(a_waitrequest), 32'(!exp_ga));
    check("b_waitrequest", 32'(b_waitrequest), 32'(!exp_gb));
    check("a_readdatavalid", 32'(a_readdatavalid), 32'(ev_a));
    check("b_readdatavalid", 32'(b_readdatavalid), 32'(ev_b));
    check("a_readdata", a_readdata, ed_a);
    check("b_readdata", b_readdata, ed_b);
    if (exp_ga && a_read)  sb.push_back('{1'b0, ref_read(int'(a_address)), cyc + 1});
    if (exp_ga && a_write) ref_write(int'(a_address), a_writedata, a_byteenable);
    if (exp_gb && b_read)  sb.push_back('{1'b1, ref_read(int'(b_address)), cyc + 1});
    if (exp_gb && b_write) ref_write(int'(b_address), b_writedata, b_byteenable);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    a_read = 0; a_write = 0; b_read = 0; b_write = 0;
    a_byteenable = 4'hF; b_byteenable = 4'hF;
  endtask

  task automatic check_reset_vals();
    check("rst_a_wait", 32'(a_waitrequest), 32'd1);
    check("rst_b_wait", 32'(b_waitrequest), 32'd1);
    check("rst_a_rdv", 32'(a_readdatavalid), 32'd0);
    check("rst_b_rdv", 32'(b_readdatavalid), 32'd0);
    check("rst_a_rd", a_readdata, 32'd0);
    check("rst_b_rd", b_readdata, 32'd0);
    check("rst_cs", 32'(sram_chipselect), 32'd0);
    check("rst_wr", 32'(sram_write), 32'd0);
    check("rst_clken", 32'(sram_clken), 32'd1);
    check("rst_reset_req", 32'(sram_reset_req), 32'd0);
    check("rst_ack", 32'(reset_ack), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < int'(WORDS); i++) mem[i] = 32'h0;
    mem_rd_q = '0;
    reset = 1; reset_req_in = 0;
    a_address = '0; b_address = '0; a_writedata = '0; b_writedata = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 0;

    // Seed words 1 and 2; B goes last so contention starts with A.
    a_write = 1; a_address = 17'h1; a_writedata = 32'h0000_1111; step(1, 0);
    idle(); b_write = 1; b_address = 17'h2; b_writedata = 32'h0000_2222; step(0, 1);

    // Continuous contention: alternating A,B grants.
    idle(); a_read = 1; a_address = 17'h1; b_read = 1; b_address = 17'h2;
    for (int i = 0; i < 6; i++) step(i % 2 == 0, i % 2 == 1);
    idle(); step(0, 0);

    // A-only write then read.
    a_write = 1; a_address = 17'h10; a_writedata = 32'hDEAD_BEEF; step(1, 0);
    idle(); a_read = 1; a_address = 17'h10; step(1, 0);
    idle(); step(0, 0);

    // Byte-lane write from B.
    a_write = 1; a_address = 17'h20; a_writedata = 32'h1122_3344; step(1, 0);
    idle(); b_write = 1; b_address = 17'h20; b_writedata = 32'hAABB_CCDD; b_byteenable = 4'b0101;
    step(0, 1);
    idle(); b_read = 1; b_address = 17'h20; step(0, 1);
    idle(); step(0, 0);
    check("byte_lane_ref", ref_read(32'h20), 32'h11BB_33DD);

    // Range boundary.
    a_write = 1; a_address = 17'(WORDS - 1); a_writedata = 32'hCAFE_F00D; step(1, 0);
    idle(); a_read = 1; a_address = 17'(WORDS - 1); step(1, 0);
    idle(); b_read = 1; b_address = 17'(WORDS); #1;
    check("oor_read_cs", 32'(sram_chipselect), 32'd0);
    step(0, 1);
    idle(); a_write = 1; a_address = 17'd130000; a_writedata = 32'h5555_AAAA; #1;
    check("oor_write_cs", 32'(sram_chipselect), 32'd0);
    step(1, 0);
    idle(); a_read = 1; a_address = 17'(WORDS - 1); step(1, 0);
    idle(); step(0, 0);

    // Quiesce with a read in flight.
    a_read = 1; a_address = 17'h10; step(1, 0);
    reset_req_in = 1; b_read = 1; b_address = 17'h2;
    n = 0;
    while (!reset_ack && n < 4) begin step(0, 0); n++; end
    check("ack_latency", 32'(n), 32'd2);
    check("halt_clken", 32'(sram_clken), 32'd0);
    check("halt_reset_req", 32'(sram_reset_req), 32'd1);
    step(0, 0);
    reset_req_in = 0; b_read = 0; step(0, 0);
    step(1, 0);
    idle(); step(0, 0);

    // Reset with a read in flight: the read is discarded.
    a_read = 1; a_address = 17'h10; step(1, 0);
    reset = 1; a_read = 1; b_read = 1; sb.delete(); #1;
    check_reset_vals();
    step(0, 0);
    step(0, 0);
    reset = 0; step(1, 0);
    idle(); step(0, 0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
